seq_addsub_unit: RTL and testbench

Parametrised, multi-cycle two's-complement add/subtract unit for the sequential core's execute stage. It replaces the single-cycle 64-bit ripple adder with a chunked carry chain. Each cycle it resolves one CHUNK-bit slice, and it adds subtract mode, zero/negative flags and a valid/ready handshake on both sides. The execute controller stalls on `in_ready`/`out_valid`.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/chunk_adder.sv | 26 ++
 rtl/seq_addsub_unit.sv | 125 ++++++++++++
 tb/tb_seq_addsub_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and default geometry for the sequential add/subtract unit.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_CHUNK = 16;

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple-carry adder for one slice of the sequential carry chain.
module chunk_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
      assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = c[W];

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle two's-complement add/subtract: one CHUNK-bit slice per cycle,
// valid/ready on both sides, flags registered when the result completes.
module seq_addsub_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_width
      $error("seq_addsub_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e             state;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_op;
  logic [WIDTH-1:0]   b_eff;
  logic               cy;

  logic [CHUNK-1:0]   a_slice;
  logic [CHUNK-1:0]   b_slice;
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_next;
  logic               last;

  // Constant-index loops keep the slice muxes free of variable part-selects.
  always_comb begin
    a_slice  = '0;
    b_slice  = '0;
    sum_next = sum;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        a_slice                    = a_op[i*CHUNK +: CHUNK];
        b_slice                    = b_eff[i*CHUNK +: CHUNK];
        sum_next[i*CHUNK +: CHUNK] = slice_sum;
      end
    end
  end

  assign last = (idx == IDX_W'(NCHUNK - 1));

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (cy),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      a_op      <= '0;
      b_eff     <= '0;
      cy        <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      negative  <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_op     <= a;
            b_eff    <= (op_e'(op) == OP_SUB) ? ~b : b;
            cy       <= op;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum <= sum_next;
          cy  <= slice_cout;
          if (last) begin
            idx       <= '0;
            carry     <= slice_cout;
            overflow  <= (a_op[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum_next[WIDTH-1] != a_op[WIDTH-1]);
            zero      <= (sum_next == '0);
            negative  <= sum_next[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Directed bench: three unit instances (CHUNK 16, 64, 8) checked against hand-computed results.
`timescale 1ns/1ps
module tb_seq_addsub_unit;

  localparam int ND = 3;

  function automatic int chunk_of(input int d);
    return (d == 0) ? 16 : (d == 1) ? 64 : 8;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n     [ND];
  logic        in_valid  [ND];
  logic        op        [ND];
  logic [63:0] a         [ND];
  logic [63:0] b         [ND];
  logic        out_ready [ND];
  logic        in_ready  [ND];
  logic        out_valid [ND];
  logic [63:0] sum       [ND];
  logic        carry     [ND];
  logic        overflow  [ND];
  logic        zero      [ND];
  logic        negative  [ND];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      seq_addsub_unit #(.WIDTH(64), .CHUNK(chunk_of(gi))) u_dut (
        .clk       (clk),
        .rst_n     (rst_n[gi]),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .op        (op[gi]),
        .a         (a[gi]),
        .b         (b[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .sum       (sum[gi]),
        .carry     (carry[gi]),
        .overflow  (overflow[gi]),
        .zero      (zero[gi]),
        .negative  (negative[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int d, input logic o, input logic [63:0] va, input logic [63:0] vb,
                        input logic [63:0] esum, input logic ec, input logic ev,
                        input logic ez, input logic en);
    int n;
    n = 0;
    while (!in_ready[d] && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_before", {63'd0, in_ready[d]}, 64'd1);
    in_valid[d] = 1'b1;
    op[d]       = o;
    a[d]        = va;
    b[d]        = vb;
    tick();
    // Scramble operands after accept; the unit must have sampled them already.
    in_valid[d] = 1'b0;
    op[d]       = ~o;
    a[d]        = ~va;
    b[d]        = ~vb;
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid[d] && n < 50);
    check("latency",   64'(n + 1), 64'(64 / chunk_of(d) + 1));
    check("sum",       sum[d], esum);
    check("carry",     {63'd0, carry[d]},    {63'd0, ec});
    check("overflow",  {63'd0, overflow[d]}, {63'd0, ev});
    check("zero",      {63'd0, zero[d]},     {63'd0, ez});
    check("negative",  {63'd0, negative[d]}, {63'd0, en});
    check("busy_ready", {63'd0, in_ready[d]}, 64'd0);
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
    check("post_valid", {63'd0, out_valid[d]}, 64'd0);
    check("post_ready", {63'd0, in_ready[d]},  64'd1);
    $display("txn chunk=%0d op=%0d a=%h b=%h sum=%h c=%0d v=%0d z=%0d n=%0d lat=%0d",
             chunk_of(d), o, va, vb, sum[d], carry[d], overflow[d], zero[d], negative[d], n + 1);
  endtask

  initial begin
    int n;
    int pulses;
    for (int d = 0; d < ND; d++) begin
      rst_n[d]     = 1'b0;
      in_valid[d]  = 1'b0;
      op[d]        = 1'b0;
      a[d]         = '0;
      b[d]         = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) tick();
    for (int d = 0; d < ND; d++) begin
      check("rst_in_ready",  {63'd0, in_ready[d]},  64'd1);
      check("rst_out_valid", {63'd0, out_valid[d]}, 64'd0);
      check("rst_sum",       sum[d], 64'd0);
      check("rst_zero",      {63'd0, zero[d]},     64'd1);
      check("rst_carry",     {63'd0, carry[d]},    64'd0);
      check("rst_negative",  {63'd0, negative[d]}, 64'd0);
      rst_n[d] = 1'b1;
    end
    tick();

    for (int d = 0; d < ND; d++) begin
      run_op(d, 1'b0, 64'd7, 64'd1, 64'd8, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(d, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFD,
             64'hFFFF_FFFF_FFFF_FFF6, 1'b1, 1'b0, 1'b0, 1'b1);
      run_op(d, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op(d, 1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(d, 1'b1, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    end

    // Backpressure on the default instance.
    in_valid[0] = 1'b1;
    op[0]       = 1'b0;
    a[0]        = 64'd7;
    b[0]        = 64'd1;
    tick();
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid", {63'd0, out_valid[0]}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = 1'b1;
      op[0]       = 1'b1;
      a[0]        = {$urandom, $urandom};
      b[0]        = {$urandom, $urandom};
      tick();
      check("bp_sum",   sum[0], 64'd8);
      check("bp_zero",  {63'd0, zero[0]},      64'd0);
      check("bp_ready", {63'd0, in_ready[0]},  64'd0);
      check("bp_hold",  {63'd0, out_valid[0]}, 64'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    out_ready[0] = 1'b0;
    check("bp_release_ready", {63'd0, in_ready[0]},  64'd1);
    check("bp_release_valid", {63'd0, out_valid[0]}, 64'd0);
    $display("txn backpressure chunk=16 held=10 sum=%h", sum[0]);

    // Reset two cycles after accept aborts the operation; early out_ready is harmless.
    in_valid[0] = 1'b1;
    op[0]       = 1'b0;
    a[0]        = 64'd3;
    b[0]        = 64'd4;
    tick();
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    tick();
    rst_n[0] = 1'b0;
    tick();
    check("abort_in_ready",  {63'd0, in_ready[0]},  64'd1);
    check("abort_out_valid", {63'd0, out_valid[0]}, 64'd0);
    check("abort_zero",      {63'd0, zero[0]},      64'd1);
    check("abort_sum",       sum[0], 64'd0);
    rst_n[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid[0]) pulses++;
    end
    out_ready[0] = 1'b0;
    check("abort_no_pulse", 64'(pulses), 64'd0);
    $display("txn reset_abort chunk=16 pulses=%0d", pulses);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
